delta_calc_seq: RTL and testbench

//   Sequential discriminant engine: computes delta = b*b - 4*a*c for signed coefficients.

---
 rtl/quad_pkg.sv | 18 +
 rtl/seq_mult_u.sv | 80 ++++++++
 rtl/delta_calc_seq.sv | 172 +++++++++++++++++
 tb/tb_delta_calc_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared definitions for the quadratic solver pipeline: widths, discriminant FSM
// encoding and the saturation bounds the sqrt stage also relies on.
package quad_pkg;

  localparam int COEF_W  = 8;
  localparam int DELTA_W = 16;

  typedef logic [1:0] delta_state_t;

  localparam delta_state_t IDLE    = 2'd0;
  localparam delta_state_t MUL_BB  = 2'd1;
  localparam delta_state_t MUL_AC  = 2'd2;
  localparam delta_state_t COMBINE = 2'd3;

  localparam logic signed [DELTA_W-1:0] DELTA_MAX = {1'b0, {(DELTA_W-1){1'b1}}};
  localparam logic signed [DELTA_W-1:0] DELTA_MIN = {1'b1, {(DELTA_W-1){1'b0}}};

endpackage

// File: rtl/seq_mult_u.sv
// Unsigned shift-add multiplier. The first partial product is folded into the load
// cycle so the full product is on p with rdy high exactly W cycles after load.
module seq_mult_u
  import quad_pkg::*;
#(
  parameter int W = COEF_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic [2*W-1:0] p,
  output logic           rdy
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           run_q, run_d;
  logic           rdy_q, rdy_d;

  // next-state: load takes step one, then one shift-add step per cycle
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    rdy_d    = rdy_q;
    if (load) begin
      acc_d    = y[0] ? {{W{1'b0}}, x} : {(2*W){1'b0}};
      mcand_d  = {{(W-1){1'b0}}, x, 1'b0};
      mplier_d = y >> 1;
      cnt_d    = CW'(W - 1);
      run_d    = (W > 1);
      rdy_d    = (W == 1);
    end else if (run_q) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : {(2*W){1'b0}});
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        run_d = 1'b0;
        rdy_d = 1'b1;
      end else begin
        run_d = 1'b1;
        rdy_d = 1'b0;
      end
    end else begin
      run_d = 1'b0;
    end
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= {(2*W){1'b0}};
      mcand_q  <= {(2*W){1'b0}};
      mplier_q <= {W{1'b0}};
      cnt_q    <= {CW{1'b0}};
      run_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      rdy_q    <= rdy_d;
    end
  end

  assign p   = acc_q;
  assign rdy = rdy_q;

endmodule

// File: rtl/delta_calc_seq.sv
// Sequential discriminant engine: delta = b*b - 4*a*c, saturated to DW bits, built
// around one shared shift-add multiplier and a start/busy/done handshake.
module delta_calc_seq
  import quad_pkg::*;
#(
  parameter int W  = COEF_W,
  parameter int DW = DELTA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [W-1:0]  c,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] delta,
  output logic          neg,
  output logic          sat
);

  // wide enough for b*b - 4*a*c without overflow and for the DW-range compare
  localparam int IW = (2*W + 3 > DW + 1) ? 2*W + 3 : DW + 1;
  localparam logic signed [IW-1:0] T_MAX = {{(IW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [IW-1:0] T_MIN = {{(IW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // read as unsigned, the W-bit result already holds 2^(W-1) for the most negative input
  function automatic logic [W-1:0] mag_of(input logic [W-1:0] x);
    return x[W-1] ? (~x + W'(1)) : x;
  endfunction

  delta_state_t   state_q, state_d;
  logic [W-1:0]   mag_a_q, mag_a_d;
  logic [W-1:0]   mag_c_q, mag_c_d;
  logic           sgn_q, sgn_d;
  logic [2*W-1:0] bb_q, bb_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [DW-1:0]  delta_q, delta_d;
  logic           neg_q, neg_d;
  logic           sat_q, sat_d;

  logic           mul_load_s;
  logic [W-1:0]   mul_x_s, mul_y_s;
  logic [2*W-1:0] mul_p_s;
  logic           mul_rdy_s;

  logic signed [IW-1:0] ac_s, p_ac_s, t_s;
  logic                 sat_hi_s, sat_lo_s;
  logic [DW-1:0]        delta_sat_s;

  seq_mult_u #(.W(W)) u_mult (
    .clk  (clk),
    .rst  (rst),
    .load (mul_load_s),
    .x    (mul_x_s),
    .y    (mul_y_s),
    .p    (mul_p_s),
    .rdy  (mul_rdy_s)
  );

  // combine: sign-correct a*c, subtract 4x from b*b, clip to the DW range
  always_comb begin
    ac_s        = $signed({{(IW-2*W){1'b0}}, mul_p_s});
    p_ac_s      = sgn_q ? -ac_s : ac_s;
    t_s         = $signed({{(IW-2*W){1'b0}}, bb_q}) - (p_ac_s <<< 2);
    sat_hi_s    = (t_s > T_MAX);
    sat_lo_s    = (t_s < T_MIN);
    if (sat_hi_s) begin
      delta_sat_s = {1'b0, {(DW-1){1'b1}}};
    end else if (sat_lo_s) begin
      delta_sat_s = {1'b1, {(DW-1){1'b0}}};
    end else begin
      delta_sat_s = t_s[DW-1:0];
    end
  end

  // FSM and operand sequencing into the shared multiplier
  always_comb begin
    state_d    = state_q;
    mag_a_d    = mag_a_q;
    mag_c_d    = mag_c_q;
    sgn_d      = sgn_q;
    bb_d       = bb_q;
    done_d     = 1'b0;
    delta_d    = delta_q;
    neg_d      = neg_q;
    sat_d      = sat_q;
    mul_load_s = 1'b0;
    mul_x_s    = {W{1'b0}};
    mul_y_s    = {W{1'b0}};
    case (state_q)
      IDLE: begin
        // a start coinciding with done is dropped, so back-to-back runs are 19 cycles apart
        if (start && !done_q) begin
          state_d    = MUL_BB;
          mag_a_d    = mag_of(a);
          mag_c_d    = mag_of(c);
          sgn_d      = a[W-1] ^ c[W-1];
          mul_load_s = 1'b1;
          mul_x_s    = mag_of(b);
          mul_y_s    = mag_of(b);
        end else begin
          state_d = IDLE;
        end
      end
      MUL_BB: begin
        if (mul_rdy_s) begin
          bb_d       = mul_p_s;
          mul_load_s = 1'b1;
          mul_x_s    = mag_a_q;
          mul_y_s    = mag_c_q;
          state_d    = MUL_AC;
        end else begin
          state_d = MUL_BB;
        end
      end
      MUL_AC: begin
        if (mul_rdy_s) begin
          state_d = COMBINE;
        end else begin
          state_d = MUL_AC;
        end
      end
      COMBINE: begin
        delta_d = delta_sat_s;
        neg_d   = t_s[IW-1];
        sat_d   = sat_hi_s | sat_lo_s;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mag_a_q <= {W{1'b0}};
      mag_c_q <= {W{1'b0}};
      sgn_q   <= 1'b0;
      bb_q    <= {(2*W){1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      delta_q <= {DW{1'b0}};
      neg_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_a_q <= mag_a_d;
      mag_c_q <= mag_c_d;
      sgn_q   <= sgn_d;
      bb_q    <= bb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      delta_q <= delta_d;
      neg_q   <= neg_d;
      sat_q   <= sat_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign delta = delta_q;
  assign neg   = neg_q;
  assign sat   = sat_q;

endmodule

// File: tb/tb_delta_calc_seq.sv
// Scoreboard bench for delta_calc_seq: directed cases, handshake timing, reset abort
// and a continuous-start random burst against a b*b-4*a*c reference.
module tb_delta_calc_seq;

  typedef struct packed {
    logic [15:0] delta;
    logic        neg;
    logic        sat;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              start;
  logic signed [7:0] a_i, b_i, c_i;
  logic              busy, done, neg, sat;
  logic [15:0]       delta;

  exp_t q[$];
  int   n_checks;
  int   n_errors;
  int   cyc;
  int   last_done;
  bit   cont_mode;

  delta_calc_seq #(.W(8), .DW(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a_i),
    .b     (b_i),
    .c     (c_i),
    .busy  (busy),
    .done  (done),
    .delta (delta),
    .neg   (neg),
    .sat   (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic signed [7:0] ma, mb, mc);
    exp_t e;
    int   t;
    t = int'(mb) * int'(mb) - 4 * int'(ma) * int'(mc);
    e.neg = (t < 0);
    if (t > 32767) begin
      e.delta = 16'h7FFF;
      e.sat   = 1'b1;
    end else if (t < -32768) begin
      e.delta = 16'h8000;
      e.sat   = 1'b1;
    end else begin
      e.delta = 16'(t);
      e.sat   = 1'b0;
    end
    return e;
  endfunction

  function automatic logic signed [7:0] pick();
    case ($urandom_range(0, 5))
      0:       return 8'sh80;
      1:       return 8'sd127;
      2:       return 8'sd0;
      default: return 8'($urandom);
    endcase
  endfunction

  // output monitor: every done pops one expectation
  always @(negedge clk) begin
    exp_t e;
    if (!cont_mode) last_done = -1;
    if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("delta", {16'd0, delta}, {16'd0, e.delta});
        chk("neg", {31'd0, neg}, {31'd0, e.neg});
        chk("sat", {31'd0, sat}, {31'd0, e.sat});
      end
      if (cont_mode && last_done >= 0)
        chk("done_spacing_ge19", {31'd0, (cyc - last_done) >= 19}, 32'd1);
      last_done = cyc;
    end
  end

  // mode: 0 plain, 1 timing checks, 2 ignored start at cycle 5, 3 reset at cycle 9
  task automatic do_op(input logic signed [7:0] ta, tb, tc, input int mode);
    int k;
    @(negedge clk);
    a_i = ta; b_i = tb; c_i = tc; start = 1'b1;
    q.push_back(model(ta, tb, tc));
    @(negedge clk);
    start = 1'b0;
    a_i = 8'($urandom); b_i = 8'($urandom); c_i = 8'($urandom);
    k = 1;
    while (k <= 40) begin
      if (mode == 1) chk("busy", {31'd0, busy}, {31'd0, (k <= 17)});
      if (mode == 2 && k == 5) begin
        start = 1'b1; a_i = 8'sd7; b_i = 8'sd100; c_i = -8'sd3;
      end
      if (mode == 2 && k == 6) start = 1'b0;
      if (mode == 3 && k == 9) begin
        rst = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_delta", {16'd0, delta}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        void'(q.pop_back());
        repeat (4) begin
          @(negedge clk);
          chk("rst_no_done", {31'd0, done}, 32'd0);
        end
        rst = 1'b0;
        return;
      end
      if (done) break;
      @(negedge clk);
      k++;
    end
    chk("latency", k, 32'd18);
  endtask

  task automatic run_burst(input int n);
    logic signed [7:0] ra, rb, rc;
    int k;
    cont_mode = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ra = pick(); rb = pick(); rc = pick();
      a_i = ra; b_i = rb; c_i = rc; start = 1'b1;
      q.push_back(model(ra, rb, rc));
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!done && k < 40);
      chk("burst_done", {31'd0, done}, 32'd1);
    end
    start = 1'b0;
    cont_mode = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; last_done = -1; cont_mode = 1'b0;
    rst = 1'b1; start = 1'b0; a_i = 8'sd0; b_i = 8'sd0; c_i = 8'sd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_delta", {16'd0, delta}, 32'd0);
    chk("reset_neg", {31'd0, neg}, 32'd0);
    chk("reset_sat", {31'd0, sat}, 32'd0);
    rst = 1'b0;

    do_op(8'sd1, 8'sd5, 8'sd6, 1);
    do_op(8'sd1, 8'sd2, 8'sd1, 0);
    do_op(8'sd1, 8'sd0, 8'sd1, 0);
    do_op(8'sd1, -8'sd18, 8'sd0, 0);
    do_op(8'sh80, 8'sh80, 8'sd127, 0);
    do_op(8'sd127, 8'sd0, 8'sd127, 0);
    do_op(8'sd3, 8'sd10, 8'sd2, 2);
    do_op(8'sd2, 8'sd9, 8'sd1, 3);
    do_op(8'sd2, 8'sd9, 8'sd1, 0);
    run_burst(500);

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
